fpu_mul_arbiter: RTL and testbench

Shares a single 24x24 `multiplier_24` mantissa multiplier between two FPU requesters: port A for FMUL/FMA mantissa products and port B for the FDIV/FSQRT iteration unit. It performs round-robin arbitration with valid/ready handshakes and tracks the in-flight operation through the multiplier's internal pipeline register. Each product is delivered, in order, through a 2-entry result FIFO owned by the requester. The block sits between the FPU arithmetic issue logic and `multiplier_24`.

---
 rtl/fpu_mul_pkg.sv | 14 +
 rtl/mul_result_fifo.sv | 56 +++++
 rtl/multiplier_24.sv | 30 +++
 rtl/fpu_mul_arbiter.sv | 136 +++++++++++++
 tb/tb_fpu_mul_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fpu_mul_pkg.sv
// Shared constants for the FPU mantissa-multiplier arbiter and its result FIFOs.
package fpu_mul_pkg;

  localparam int unsigned MANT_W         = 24;
  localparam int unsigned PROD_W         = 48;
  localparam int unsigned MUL_LAT        = 1;
  localparam int unsigned RES_FIFO_DEPTH = 2;
  localparam int unsigned OCC_W          = 2;
  localparam int unsigned PTR_W          = $clog2(RES_FIFO_DEPTH);

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/mul_result_fifo.sv
// Two-entry per-requester result FIFO; head is presented directly from storage.
module mul_result_fifo
  import fpu_mul_pkg::*;
#(
  parameter int unsigned W = 52
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [OCC_W-1:0] count_o,
  output logic [W-1:0]     head_o
);

  logic [W-1:0]     mem_q [RES_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] count_q;
  logic             pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Flush empties the queue but leaves stale data behind an invalid head.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(RES_FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + OCC_W'(push_i) - OCC_W'(pop_ok);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (reset || flush)
    !(push_i && !pop_ok && (count_q == OCC_W'(RES_FIFO_DEPTH))))
    else $error("mul_result_fifo: push into full fifo");

endmodule

// File: rtl/multiplier_24.sv
// 24x24 mantissa multiplier with one internal register stage on the partial products.
module multiplier_24
  import fpu_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MANT_W-1:0] M_inA,
  input  logic [MANT_W-1:0] M_inB,
  output logic [PROD_W-1:0] P
);

  localparam int unsigned HALF_W = MANT_W / 2;
  localparam int unsigned PP_W   = MANT_W + HALF_W;

  logic [PP_W-1:0] pp_lo_q;
  logic [PP_W-1:0] pp_hi_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pp_lo_q <= '0;
      pp_hi_q <= '0;
    end else begin
      pp_lo_q <= PP_W'(M_inA) * PP_W'(M_inB[HALF_W-1:0]);
      pp_hi_q <= PP_W'(M_inA) * PP_W'(M_inB[MANT_W-1:HALF_W]);
    end
  end

  assign P = PROD_W'(pp_lo_q) + (PROD_W'(pp_hi_q) << HALF_W);

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Round-robin sharing of one multiplier_24 between the FMUL/FMA port (A) and
// the FDIV/FSQRT port (B), with in-flight tracking and per-port result FIFOs.
module fpu_mul_arbiter
  import fpu_mul_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [MANT_W-1:0] a_op_a,
  input  logic [MANT_W-1:0] a_op_b,
  input  logic [TAG_W-1:0]  a_tag,
  output logic              a_res_valid,
  input  logic              a_res_ready,
  output logic [PROD_W-1:0] a_res_p,
  output logic [TAG_W-1:0]  a_res_tag,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [MANT_W-1:0] b_op_a,
  input  logic [MANT_W-1:0] b_op_b,
  input  logic [TAG_W-1:0]  b_tag,
  output logic              b_res_valid,
  input  logic              b_res_ready,
  output logic [PROD_W-1:0] b_res_p,
  output logic [TAG_W-1:0]  b_res_tag
);

  localparam int unsigned ENT_W = PROD_W + TAG_W;

  logic             prio_q,     prio_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_id_q,    s1_id_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic [OCC_W-1:0]  cnt_a, cnt_b;
  logic [OCC_W-1:0]  occ_a, occ_b;
  logic [ENT_W-1:0]  head_a, head_b;
  logic              blocked;
  logic              pop_a, pop_b;
  logic              push_a, push_b;
  logic              elig_a, elig_b;
  logic              gnt_a, gnt_b;
  logic [MANT_W-1:0] m_in_a, m_in_b;
  logic [PROD_W-1:0] m_p;

  assign blocked     = reset || flush;
  assign a_res_valid = (cnt_a != '0);
  assign b_res_valid = (cnt_b != '0);
  assign a_res_p     = head_a[ENT_W-1 -: PROD_W];
  assign a_res_tag   = head_a[TAG_W-1:0];
  assign b_res_p     = head_b[ENT_W-1 -: PROD_W];
  assign b_res_tag   = head_b[TAG_W-1:0];
  assign a_ready     = gnt_a;
  assign b_ready     = gnt_b;
  assign push_a      = s1_valid_q && (s1_id_q == REQ_A);
  assign push_b      = s1_valid_q && (s1_id_q == REQ_B);

  // A same-cycle pop frees a slot, so a full requester can still be granted.
  always_comb begin
    pop_a      = a_res_valid && a_res_ready && !blocked;
    pop_b      = b_res_valid && b_res_ready && !blocked;
    occ_a      = cnt_a + OCC_W'(push_a);
    occ_b      = cnt_b + OCC_W'(push_b);
    elig_a     = a_valid && !blocked &&
                 ((occ_a - OCC_W'(pop_a)) < OCC_W'(RES_FIFO_DEPTH));
    elig_b     = b_valid && !blocked &&
                 ((occ_b - OCC_W'(pop_b)) < OCC_W'(RES_FIFO_DEPTH));
    gnt_a      = elig_a && (!elig_b || (prio_q == REQ_A));
    gnt_b      = elig_b && (!elig_a || (prio_q == REQ_B));

    prio_d     = prio_q;
    s1_valid_d = gnt_a || gnt_b;
    s1_id_d    = gnt_b ? REQ_B : REQ_A;
    s1_tag_d   = gnt_b ? b_tag : a_tag;
    m_in_a     = '0;
    m_in_b     = '0;
    if (gnt_a) begin
      prio_d = REQ_B;
      m_in_a = a_op_a;
      m_in_b = a_op_b;
    end else if (gnt_b) begin
      prio_d = REQ_A;
      m_in_a = b_op_a;
      m_in_b = b_op_b;
    end
  end

  // Stage register mirrors the multiplier's internal partial-product register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q     <= REQ_A;
      s1_valid_q <= 1'b0;
      s1_id_q    <= REQ_A;
      s1_tag_q   <= '0;
    end else begin
      prio_q     <= prio_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  multiplier_24 u_mul (
    .clk   (clk),
    .rst_n (~reset),
    .M_inA (m_in_a),
    .M_inB (m_in_b),
    .P     (m_p)
  );

  mul_result_fifo #(.W(ENT_W)) u_fifo_a (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .push_i      (push_a),
    .push_data_i ({m_p, s1_tag_q}),
    .pop_i       (pop_a),
    .count_o     (cnt_a),
    .head_o      (head_a)
  );

  mul_result_fifo #(.W(ENT_W)) u_fifo_b (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .push_i      (push_b),
    .push_data_i ({m_p, s1_tag_q}),
    .pop_i       (pop_b),
    .count_o     (cnt_b),
    .head_o      (head_b)
  );

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed plus randomized bench for fpu_mul_arbiter against a queue-based
// model of grants, occupancy and in-order result delivery.
module tb_fpu_mul_arbiter;

  localparam int unsigned TAG_W = 4;

  logic              clk = 1'b0;
  logic              reset, flush;
  logic              a_valid, a_ready, a_res_valid, a_res_ready;
  logic [23:0]       a_op_a, a_op_b;
  logic [TAG_W-1:0]  a_tag, a_res_tag;
  logic [47:0]       a_res_p;
  logic              b_valid, b_ready, b_res_valid, b_res_ready;
  logic [23:0]       b_op_a, b_op_b;
  logic [TAG_W-1:0]  b_tag, b_res_tag;
  logic [47:0]       b_res_p;

  always #5 clk = ~clk;

  fpu_mul_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .a_valid(a_valid), .a_ready(a_ready), .a_op_a(a_op_a), .a_op_b(a_op_b),
    .a_tag(a_tag), .a_res_valid(a_res_valid), .a_res_ready(a_res_ready),
    .a_res_p(a_res_p), .a_res_tag(a_res_tag),
    .b_valid(b_valid), .b_ready(b_ready), .b_op_a(b_op_a), .b_op_b(b_op_b),
    .b_tag(b_tag), .b_res_valid(b_res_valid), .b_res_ready(b_res_ready),
    .b_res_p(b_res_p), .b_res_tag(b_res_tag)
  );

  typedef struct {
    logic [47:0]      p;
    logic [TAG_W-1:0] tag;
    int               t;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  bit   ptr_b;
  int   cyc, checks, errors;
  bit   started, just_reset;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  // One clock: check combinational/registered outputs, advance the model, step.
  task automatic tick();
    bit blk, va, vb, pa, pb, ea, eb, ga, gb;
    ent_t e;
    #1;
    blk = reset || flush;
    va  = (qa.size() > 0) && (qa[0].t <= cyc - 2);
    vb  = (qb.size() > 0) && (qb[0].t <= cyc - 2);
    pa  = va && a_res_ready && !blk;
    pb  = vb && b_res_ready && !blk;
    ea  = a_valid && !blk && ((qa.size() - int'(pa)) < 2);
    eb  = b_valid && !blk && ((qb.size() - int'(pb)) < 2);
    ga  = ea && (!eb || !ptr_b);
    gb  = eb && (!ea || ptr_b);
    chk("a_ready", 64'(a_ready), 64'(ga));
    chk("b_ready", 64'(b_ready), 64'(gb));
    if (started) begin
      chk("a_res_valid", 64'(a_res_valid), 64'(va));
      chk("b_res_valid", 64'(b_res_valid), 64'(vb));
      if (va) begin
        chk("a_res_p", 64'(a_res_p), 64'(qa[0].p));
        chk("a_res_tag", 64'(a_res_tag), 64'(qa[0].tag));
      end
      if (vb) begin
        chk("b_res_p", 64'(b_res_p), 64'(qb[0].p));
        chk("b_res_tag", 64'(b_res_tag), 64'(qb[0].tag));
      end
      if (just_reset) begin
        chk("rst_a_res_p", 64'(a_res_p), 64'd0);
        chk("rst_a_res_tag", 64'(a_res_tag), 64'd0);
        chk("rst_b_res_p", 64'(b_res_p), 64'd0);
        chk("rst_b_res_tag", 64'(b_res_tag), 64'd0);
      end
    end
    if (reset) begin
      qa.delete(); qb.delete(); ptr_b = 1'b0;
    end else if (flush) begin
      qa.delete(); qb.delete();
    end else begin
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      if (ga) begin
        e.p = 48'(a_op_a) * 48'(a_op_b); e.tag = a_tag; e.t = cyc;
        qa.push_back(e);
        ptr_b = 1'b1;
      end
      if (gb) begin
        e.p = 48'(b_op_a) * 48'(b_op_b); e.tag = b_tag; e.t = cyc;
        qb.push_back(e);
        ptr_b = 1'b0;
      end
    end
    just_reset = reset;
    @(posedge clk);
    cyc++;
    started = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_ops();
    a_op_a = 24'($urandom); a_op_b = 24'($urandom); a_tag = TAG_W'($urandom);
    b_op_a = 24'($urandom); b_op_b = 24'($urandom); b_tag = TAG_W'($urandom);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; ptr_b = 1'b0;
    started = 1'b0; just_reset = 1'b0;
    reset = 1'b1; flush = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_res_ready = 1'b1; b_res_ready = 1'b1;
    rand_ops();
    @(negedge clk);

    // reset
    tick(); tick();
    reset = 1'b0;

    // single A operation
    a_valid = 1'b1; a_op_a = 24'h800000; a_op_b = 24'h800000; a_tag = 4'd3;
    tick();
    a_valid = 1'b0;
    tick();
    chk("single_valid", 64'(a_res_valid), 64'd1);
    chk("single_p", 64'(a_res_p), 64'h400000000000);
    chk("single_tag", 64'(a_res_tag), 64'd3);
    for (int i = 0; i < 3; i++) tick();

    // contention, both consumers ready
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin rand_ops(); tick(); end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // back-pressure on A
    a_res_ready = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_ops(); a_op_a = 24'hFFFFFF; a_op_b = 24'hFFFFFF;
      tick();
    end
    chk("bp_hold_p", 64'(a_res_p), 64'hFFFFFE000001);
    chk("bp_a_ready", 64'(a_ready), 64'd0);
    a_res_ready = 1'b1;
    #1 chk("full_pop_grant", 64'(a_ready), 64'(!b_valid || !ptr_b));
    for (int i = 0; i < 4; i++) begin rand_ops(); tick(); end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // flush with one buffered and one in flight
    a_res_ready = 1'b0; a_valid = 1'b1;
    rand_ops(); tick();
    rand_ops(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; a_valid = 1'b0;
    tick();
    chk("flush_a_empty", 64'(a_res_valid), 64'd0);
    a_res_ready = 1'b1; a_valid = 1'b1; rand_ops();
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // reset mid-stream with both FIFOs holding results
    a_res_ready = 1'b0; b_res_ready = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin rand_ops(); tick(); end
    reset = 1'b1;
    tick();
    reset = 1'b0; a_res_ready = 1'b1; b_res_ready = 1'b1;
    #1 chk("post_reset_grant_a", 64'(a_ready), 64'd1);
    chk("post_reset_b_ready", 64'(b_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin rand_ops(); tick(); end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      a_valid     = ($urandom_range(3) != 0);
      b_valid     = ($urandom_range(3) != 0);
      a_res_ready = ($urandom_range(1) != 0);
      b_res_ready = ($urandom_range(2) != 0);
      flush       = ($urandom_range(39) == 0);
      reset       = ($urandom_range(99) == 0);
      tick();
    end
    reset = 1'b0; flush = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_res_ready = 1'b1; b_res_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
